// File: rtl/bcd_serial_add_ctrl_pkg.sv
// Shared constants and FSM encoding for the serial packed-BCD adder.
package bcd_pkg;
   localparam int unsigned BCD_DIGIT_W = 4;
   localparam int unsigned BCD_MAX     = 9;
   localparam int unsigned BCD_CORR    = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_e;
endpackage

// File: rtl/bcd_serial_add_ctrl_if.sv
// Request/result bundle between a request source and bcd_serial_add_ctrl.
interface bcd_serial_add_ctrl_if #(
   parameter int unsigned DIGITS = 4
) ();
   localparam int unsigned W = bcd_pkg::BCD_DIGIT_W * DIGITS;

   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
   logic         err;

   modport master (output start, a, b, cin, input busy, done, sum, cout, err);
   modport slave  (input start, a, b, cin, output busy, done, sum, cout, err);
endinterface

// File: rtl/bcd_serial_add_ctrl_digit_add.sv
// Combinational single-digit decimal adder with +6 correction above 9.
module bcd_digit_add
   import bcd_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] a,
   input  logic [BCD_DIGIT_W-1:0] b,
   input  logic                   ci,
   output logic [BCD_DIGIT_W-1:0] s,
   output logic                   co
);
   localparam int unsigned TW = BCD_DIGIT_W + 1;

   logic [TW-1:0] t;

   always_comb begin
      t = {1'b0, a} + {1'b0, b} + {{BCD_DIGIT_W{1'b0}}, ci};
      if (t > TW'(BCD_MAX)) begin
         s  = BCD_DIGIT_W'(t + TW'(BCD_CORR));
         co = 1'b1;
      end else begin
         s  = t[BCD_DIGIT_W-1:0];
         co = 1'b0;
      end
   end
endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD adder controller, LSD first, one digit per clock.
// Optional invalid-digit checking: define BCD_SERIAL_ADD_INVALID_CHECK_EN.
module bcd_serial_add_ctrl
   import bcd_pkg::*;
#(
   parameter int unsigned DIGITS = 4
) (
   input logic                  clk,
   input logic                  rst,
   bcd_serial_add_ctrl_if.slave bus
);
   localparam int unsigned W     = BCD_DIGIT_W * DIGITS;
   localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [W-1:0]     a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic             carry_q, carry_d, cout_q, cout_d;
   logic             busy_q, busy_d, done_q, done_d;

   logic [BCD_DIGIT_W-1:0] dig_a, dig_b, dig_s;
   logic                   dig_co;
   logic                   last;

   assign dig_a = a_q[BCD_DIGIT_W*idx_q +: BCD_DIGIT_W];
   assign dig_b = b_q[BCD_DIGIT_W*idx_q +: BCD_DIGIT_W];
   assign last  = (idx_q == IDX_W'(DIGITS - 1));

   bcd_digit_add u_digit_add (
      .a  (dig_a),
      .b  (dig_b),
      .ci (carry_q),
      .s  (dig_s),
      .co (dig_co)
   );

`ifdef BCD_SERIAL_ADD_INVALID_CHECK_EN
   logic err_q, err_d, flag_q, flag_d, dig_bad;
   assign dig_bad = (dig_a > BCD_DIGIT_W'(BCD_MAX)) || (dig_b > BCD_DIGIT_W'(BCD_MAX));
`endif

   // Next-state and datapath updates
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
`ifdef BCD_SERIAL_ADD_INVALID_CHECK_EN
      err_d   = err_q;
      flag_d  = flag_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = ADD;
               a_d     = bus.a;
               b_d     = bus.b;
               carry_d = bus.cin;
               idx_d   = '0;
               sum_d   = '0;
               cout_d  = 1'b0;
               busy_d  = 1'b1;
`ifdef BCD_SERIAL_ADD_INVALID_CHECK_EN
               err_d   = 1'b0;
               flag_d  = 1'b0;
`endif
            end
         end
         ADD: begin
            sum_d[BCD_DIGIT_W*idx_q +: BCD_DIGIT_W] = dig_s;
            carry_d = dig_co;
            idx_d   = IDX_W'(idx_q + 1'b1);
`ifdef BCD_SERIAL_ADD_INVALID_CHECK_EN
            flag_d  = flag_q | dig_bad;
`endif
            if (last) begin
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               cout_d  = dig_co;
`ifdef BCD_SERIAL_ADD_INVALID_CHECK_EN
               // Result is discarded when any digit of either operand was illegal
               if (flag_d) begin
                  err_d  = 1'b1;
                  sum_d  = '0;
                  cout_d = 1'b0;
               end
`endif
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef BCD_SERIAL_ADD_INVALID_CHECK_EN
         err_q   <= 1'b0;
         flag_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef BCD_SERIAL_ADD_INVALID_CHECK_EN
         err_q   <= err_d;
         flag_q  <= flag_d;
`endif
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
`ifdef BCD_SERIAL_ADD_INVALID_CHECK_EN
   assign bus.err  = err_q;
`else
   assign bus.err  = 1'b0;
`endif
endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Directed self-checking bench for bcd_serial_add_ctrl (DIGITS=4).
module tb_bcd_serial_add_ctrl;
   logic clk;
   logic rst;
   int   checks;
   int   errors;

   bcd_serial_add_ctrl_if #(.DIGITS(4)) bus ();

   bcd_serial_add_ctrl #(.DIGITS(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issue one add, wait (bounded) for done, check timing and result.
   task automatic run_add(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic ci, input logic [15:0] es, input logic ec,
                          input logic ee, input bit poke_done);
      int  lat;
      int  busy_cnt;
      bit  seen;
      lat = 0; busy_cnt = 0; seen = 0;
      @(negedge clk);
      bus.start = 1'b1; bus.a = av; bus.b = bv; bus.cin = ci;
      @(negedge clk);
      bus.start = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         if (bus.done === 1'b1) begin
            seen = 1;
            lat  = k;
         end else begin
            if (bus.busy === 1'b1) busy_cnt++;
            @(negedge clk);
         end
      end
      if (!seen) begin
         chk({tag, "_timeout"}, 64'd0, 64'd1);
      end else begin
         chk({tag, "_latency"}, 64'(lat), 64'd4);
         chk({tag, "_busycnt"}, 64'(busy_cnt), 64'd4);
         chk({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
         chk({tag, "_sum"}, 64'(bus.sum), 64'(es));
         chk({tag, "_cout"}, 64'(bus.cout), 64'(ec));
         chk({tag, "_err"}, 64'(bus.err), 64'(ee));
         if (poke_done) bus.start = 1'b1;
         @(negedge clk);
         bus.start = 1'b0;
         chk({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
         if (poke_done) chk({tag, "_done_start_ignored"}, 64'(bus.busy), 64'd0);
         @(negedge clk);
         chk({tag, "_sum_hold"}, 64'(bus.sum), 64'(es));
         if (poke_done) chk({tag, "_still_idle"}, 64'(bus.busy), 64'd0);
      end
   endtask

   initial begin
      int done_cnt;
      logic [15:0] cap_sum;
      logic        cap_cout;
      checks = 0; errors = 0;
      rst = 1'b1;
      bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk("rst_sum",  64'(bus.sum),  64'd0);
      chk("rst_cout", 64'(bus.cout), 64'd0);
      chk("rst_err",  64'(bus.err),  64'd0);
      rst = 1'b0;

      run_add("ripple", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
      run_add("mixed",  16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b0);
      run_add("cin0",   16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
      run_add("cin_rip",16'h4999, 16'h5000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);

      // Re-pulsed start and changed operands during ADD must be ignored
      @(negedge clk);
      bus.start = 1'b1; bus.a = 16'h1111; bus.b = 16'h2222; bus.cin = 1'b0;
      @(negedge clk);
      done_cnt = 0; cap_sum = '0; cap_cout = 1'bx;
      for (int i = 0; i < 12; i++) begin
         if (bus.done === 1'b1) begin
            done_cnt++;
            cap_sum  = bus.sum;
            cap_cout = bus.cout;
         end
         if (i < 3) begin
            bus.start = 1'b1; bus.a = 16'h9999; bus.b = 16'h9999; bus.cin = 1'b1;
         end else begin
            bus.start = 1'b0;
         end
         @(negedge clk);
      end
      chk("repulse_done_cnt", 64'(done_cnt), 64'd1);
      chk("repulse_sum", 64'(cap_sum), 64'h3333);
      chk("repulse_cout", 64'(cap_cout), 64'd0);

      run_add("poke_done", 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b1);

      // Reset in the middle of an addition
      @(negedge clk);
      bus.start = 1'b1; bus.a = 16'h9999; bus.b = 16'h9999; bus.cin = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
      chk("mid_busy", 64'(bus.busy), 64'd1);
      chk("mid_partial_sum", 64'(bus.sum), 64'h0098);
      #1 rst = 1'b1;
      #1;
      chk("abort_busy", 64'(bus.busy), 64'd0);
      chk("abort_done", 64'(bus.done), 64'd0);
      chk("abort_sum",  64'(bus.sum),  64'd0);
      chk("abort_cout", 64'(bus.cout), 64'd0);
      chk("abort_err",  64'(bus.err),  64'd0);
      @(negedge clk);
      rst = 1'b0;
      done_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         if (bus.done === 1'b1) done_cnt++;
         @(negedge clk);
      end
      chk("abort_no_done", 64'(done_cnt), 64'd0);
      run_add("post_rst", 16'h0505, 16'h0505, 1'b0, 16'h1010, 1'b0, 1'b0, 1'b0);

`ifdef BCD_SERIAL_ADD_INVALID_CHECK_EN
      run_add("invalid", 16'h00A0, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
      run_add("valid_clr", 16'h0012, 16'h0034, 1'b0, 16'h0046, 1'b0, 1'b0, 1'b0);
`else
      run_add("invalid_pass", 16'h00A0, 16'h0001, 1'b0, 16'h0101, 1'b0, 1'b0, 1'b0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
